// File: rtl/gpio_irq_pkg.sv
// Shared types and constants for the GPIO interrupt scheduler.
// Imported by the capture cells and the scheduler top.
package gpio_irq_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_INT0 = 2'd0;
  localparam logic [1:0] SRC_INT1 = 2'd1;
  localparam logic [1:0] SRC_PC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_e;

endpackage

// File: rtl/gpio_irq_capture.sv
// Per-source rising-edge capture with pending flag and sticky overrun.
// One instance per interrupt source.
module gpio_irq_capture (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic clr_i,
  input  logic status_clr_i,
  output logic pending_o,
  output logic overrun_o
);

  logic src_q;
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;
  logic rise;

  // A new edge beats both the ack clear and the status clear.
  always_comb begin
    rise   = src_i & ~src_q;
    pend_d = rise | (pend_q & ~clr_i);
    ovr_d  = (rise & pend_q & ~clr_i) | (ovr_q & ~status_clr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/gpio_irq_sched.sv
// Interrupt scheduler: arbitrates captured GPIO events and runs the
// request/ack/EOI handshake toward the CPU.
module gpio_irq_sched #(
  parameter int ACK_TIMEOUT = 16,
  parameter bit PRIO_ROTATE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_int0,
  input  logic       irq_int1,
  input  logic       irq_pinchange,
  input  logic [2:0] src_enable,
  input  logic       status_clr,
  input  logic       irq_ack,
  input  logic       irq_eoi,
  output logic       irq_req,
  output logic [1:0] irq_id,
  output logic       irq_busy,
  output logic [2:0] pending,
  output logic [2:0] overrun,
  output logic       ack_timeout
);

  import gpio_irq_pkg::*;

  state_e     state_q;
  logic       req_q, busy_q, tmo_q;
  logic [1:0] id_q, rr_q;
  logic [7:0] cnt_q;

  logic [2:0] src_w, clr_w, pend_w, ovr_w, cand_w;
  logic [1:0] start_w, win_w, idx;
  logic       found_w;

  assign src_w = {irq_pinchange, irq_int1, irq_int0};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cap
    assign clr_w[g] = (state_q == ST_REQ) & irq_ack
                    & (id_q == 2'(g));
    gpio_irq_capture u_cap (
      .clk          (clk),
      .reset        (reset),
      .src_i        (src_w[g]),
      .clr_i        (clr_w[g]),
      .status_clr_i (status_clr),
      .pending_o    (pend_w[g]),
      .overrun_o    (ovr_w[g])
    );
  end

  assign cand_w = pend_w & src_enable;

  // Fixed priority is the rotating search pinned to start at INT0.
  always_comb begin
    start_w = SRC_INT0;
    if (PRIO_ROTATE)
      start_w = (rr_q == SRC_PC) ? SRC_INT0 : rr_q + 2'd1;
    win_w   = SRC_INT0;
    found_w = 1'b0;
    idx     = start_w;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found_w && cand_w[idx]) begin
        win_w   = idx;
        found_w = 1'b1;
      end
      idx = (idx == SRC_PC) ? SRC_INT0 : idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      id_q    <= SRC_INT0;
      rr_q    <= SRC_PC;
      cnt_q   <= 8'd0;
    end else begin
      if (status_clr)
        tmo_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (found_w) begin
            id_q    <= win_w;
            req_q   <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            rr_q    <= id_q;
            req_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SERVICE;
          end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
            tmo_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_SERVICE: begin
          if (irq_eoi) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign irq_req     = req_q;
  assign irq_busy    = busy_q;
  assign irq_id      = id_q;
  assign pending     = pend_w;
  assign overrun     = ovr_w;
  assign ack_timeout = tmo_q;

endmodule
